// File: rtl/posit_mac_ctrl.sv
// -----------------------------------------------------------------------------
// posit_mac_ctrl
// Sequencer for the posit dot-product MAC pipeline
// (decode -> multiply -> accumulate -> encode).
//
// Behaviour:
//  - Accepts one dot-product command of cmd_len operand pairs.
//  - Streams the pairs into the decode stage through registered pipe_a/pipe_b.
//  - Owns the pipeline token shift register (vld_d) and the advance enable
//    (acc_rdy).
//  - Captures the encoder result and returns it over a valid/ready handshake.
//  - Only one command is ever in flight.
//
// Optional feature (macro PMC_STATS_EN):
//  Adds two saturating activity counters, each with its own output port:
//   - stat_busy  : cycles spent outside IDLE.
//   - stat_stall : cycles outside IDLE with hold_i high.
//
// Parameters:
//  WIDTH  posit width of the operands and the result
//  EXP    posit exponent field width (used only by the datapath)
//  DEPTH  number of pipeline stages; stage DEPTH-1 is the encode stage
//  LEN_W  width of cmd_len
//
// Ports:
//  clk_i, rstn          clock, asynchronous active-low reset
//  cmd_vld/cmd_rdy      command handshake; cmd_len = number of operand pairs
//  op_vld/op_rdy        operand handshake carrying op_a/op_b
//  hold_i               external stall that freezes the whole pipeline
//  pipe_a/pipe_b        registered operands driven into the decode stage
//  acc_first            marks the token that restarts the accumulator
//  acc_rdy              pipeline advance enable (~hold_i)
//  vld_d                pipeline token shift register
//  enc_vld/enc_data     one-cycle encoder result pulse
//  res_vld/res_rdy      result handshake carrying res_data
// -----------------------------------------------------------------------------
module posit_mac_ctrl #(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int DEPTH = 12,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_vld,
  output logic             op_rdy,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hold_i,
  output logic [WIDTH-1:0] pipe_a,
  output logic [WIDTH-1:0] pipe_b,
  output logic             acc_first,
  output logic             acc_rdy,
  output logic [DEPTH-1:0] vld_d,
  input  logic             enc_vld,
  input  logic [WIDTH-1:0] enc_data,
  output logic             res_vld,
  input  logic             res_rdy,
`ifdef PMC_STATS_EN
  output logic [31:0]      stat_busy,
  output logic [31:0]      stat_stall,
`endif
  output logic [WIDTH-1:0] res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [DEPTH-1:0]   tok_q, tok_d;
  logic [WIDTH-1:0]   pipe_a_q, pipe_a_d;
  logic [WIDTH-1:0]   pipe_b_q, pipe_b_d;
  logic               acc_first_q, acc_first_d;
  logic               res_vld_q, res_vld_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               issue_s;

  // An exponent field wider than WIDTH-3 leaves no room for sign and regime.
  // This named block only exists in such an illegal configuration, which makes
  // it easy to spot in the elaborated hierarchy.
  if (EXP > WIDTH - 3) begin : g_exp_too_wide_for_width
  end

  assign acc_rdy = ~hold_i;
  assign cmd_rdy = (state_q == S_IDLE);
  assign op_rdy  = (state_q == S_RUN) & acc_rdy;
  assign issue_s = op_vld & op_rdy;

  assign vld_d     = tok_q;
  assign pipe_a    = pipe_a_q;
  assign pipe_b    = pipe_b_q;
  assign acc_first = acc_first_q;
  assign res_vld   = res_vld_q;
  assign res_data  = res_data_q;

  // Command sequencing: next state, pair counter and result register.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    first_d    = first_q;
    res_vld_d  = res_vld_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_vld) begin
          if (cmd_len != {LEN_W{1'b0}}) begin
            rem_d   = cmd_len;
            first_d = 1'b1;
            state_d = S_RUN;
          end else begin
            // Empty dot product: answer zero without touching the pipeline.
            res_data_d = {WIDTH{1'b0}};
            res_vld_d  = 1'b1;
            state_d    = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue_s) begin
          first_d = 1'b0;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // The result register is empty here, so the one-cycle pulse is never lost.
        if (enc_vld) begin
          res_data_d = enc_data;
          res_vld_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (res_vld_q && res_rdy) begin
          res_vld_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pipeline front end: token shift, operand registers and accumulator restart flag.
  always_comb begin
    tok_d       = tok_q;
    pipe_a_d    = pipe_a_q;
    pipe_b_d    = pipe_b_q;
    acc_first_d = acc_first_q;
    if (acc_rdy) begin
      tok_d = {tok_q[DEPTH-2:0], issue_s};
      if (issue_s) begin
        pipe_a_d    = op_a;
        pipe_b_d    = op_b;
        acc_first_d = first_q;
      end else begin
        // A bubble never restarts the accumulator.
        acc_first_d = 1'b0;
      end
    end else begin
      tok_d = tok_q;
    end
  end

  // State and datapath-control registers.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rem_q       <= {LEN_W{1'b0}};
      first_q     <= 1'b0;
      tok_q       <= {DEPTH{1'b0}};
      pipe_a_q    <= {WIDTH{1'b0}};
      pipe_b_q    <= {WIDTH{1'b0}};
      acc_first_q <= 1'b0;
      res_vld_q   <= 1'b0;
      res_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      first_q     <= first_d;
      tok_q       <= tok_d;
      pipe_a_q    <= pipe_a_d;
      pipe_b_q    <= pipe_b_d;
      acc_first_q <= acc_first_d;
      res_vld_q   <= res_vld_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef PMC_STATS_EN
  logic [31:0] stat_busy_q, stat_busy_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Saturating busy/stall counters, counted only while a command is active.
  always_comb begin
    stat_busy_d  = stat_busy_q;
    stat_stall_d = stat_stall_q;
    if ((state_q != S_IDLE) && (stat_busy_q != 32'hFFFF_FFFF)) begin
      stat_busy_d = stat_busy_q + 32'd1;
    end else begin
      stat_busy_d = stat_busy_q;
    end
    if ((state_q != S_IDLE) && hold_i && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end else begin
      stat_stall_d = stat_stall_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      stat_busy_q  <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      stat_busy_q  <= stat_busy_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_busy  = stat_busy_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
